mem_store_buffer: RTL and testbench
===================================

// Module: mem_store_buffer
// PURPOSE
//  Store-side partner of the MEM load-extract path. Accepts sb/sh/sw from EX, packs byte lanes/write
//  enables, holds them in an in-order FIFO, drains one store per cycle to the shared data SRAM port
//  whenever the port is not taken by a load. Flags load-after-store hazards so the pipeline stalls.
// PARAMETERS
//  DEPTH   4   buffer entries; power of two, >= 2
//  PTR_W   2   log2(DEPTH); pointer width (count is PTR_W+1 bits)
// PORTS
//  clk              in   1   clock
//  rst              in   1   synchronous, active-high reset
//  st_valid         in   1   EX presents a store this cycle
//  st_op            in   3   {sw,sh,sb} one-hot
//  st_addr          in   32  byte address
//  st_data          in   32  rt value, unaligned (low bits significant)
//  st_ready         out  1   buffer can accept (= !full)
//  st_ades          out  1   misaligned-store error (see CONFIGURATION)
//  ld_req           in   1   MEM load wants the SRAM port this cycle
//  ld_addr          in   32  load byte address
//  ld_hazard        out  1   load overlaps a buffered store word; pipeline must stall
//  data_sram_en     out  1   SRAM access enable (store drain)
//  data_sram_wen    out  4   byte write enables
//  data_sram_addr   out  32  word-aligned address {addr[31:2],2'b00}
//  data_sram_wdata  out  32  lane-replicated write data
//  sb_empty         out  1   buffer empty
//  sb_count         out  PTR_W+1  occupied entries
// BEHAVIOUR
//  - Reset: head=tail=0, count=0; sb_empty=1, st_ready=1, all other outputs 0.
//  - Enqueue when st_valid && st_ready && st_op!=0 (&& !st_ades). st_op==0: nothing stored.
//    Multiple bits set: priority sw > sh > sb.
//  - Packing at enqueue (stored per entry: addr[31:2], wen, wdata):
//    sb: wen=4'b0001<<addr[1:0], wdata={4{data[7:0]}}
//    sh: wen=addr[1]?4'b1100:4'b0011, wdata={2{data[15:0]}}
//    sw: wen=4'b1111, wdata=data
//  - Drain: drain = !sb_empty && (!ld_req || ld_hazard). data_sram_en/wen/addr/wdata driven
//    combinationally from head entry when drain, else en=0, wen=0, addr/wdata=0. Head pops same cycle.
//  - Latency: store accepted at edge N is drainable in cycle N+1 at earliest; no same-cycle bypass.
//  - st_ready = (count != DEPTH); a pop in the same cycle does NOT free a slot for that cycle's push.
//  - Simultaneous push+pop when not full: count unchanged, both pointers advance.
//  - Pointers wrap mod DEPTH; order strictly FIFO.
//  - ld_hazard = ld_req && any valid entry with entry.addr[31:2]==ld_addr[31:2] (word granularity,
//    ignores wen). While hazard, drain continues, load holds; hazard clears once matching entries drain.
//  - No flush input: buffered stores are committed and always drain. rst mid-drain discards contents.
// CONFIGURATION
//  STORE_ALIGN_CHK_EN defined: st_ades = st_valid && ((sh && st_addr[0]) || (sw && st_addr[1:0]!=0)),
//    combinational; erroring store is not enqueued; buffer state unchanged.
//  Not defined: st_ades tied 0; sh uses addr[1] only, sw ignores addr[1:0]; all stores enqueue.
// TESTING
//  1 reset, sb addr=0x13 data=0xAB -> next cycle en=1, wen=1000, addr=0x10, wdata=0xABABABAB.
//  2 sh addr=0x22 data=0x1234, sw addr=0x40 data=0xDEADBEEF back-to-back, ld_req=0 -> drains in
//    order: (0x20,1100,0x12341234) then (0x40,1111,0xDEADBEEF); sb_empty=1 after.
//  3 ld_req=1 held, push 4 stores to non-matching addrs -> no drain, st_ready=0 at count=4, 5th push
//    rejected; drop ld_req -> 4 drains on 4 consecutive cycles.
//  4 buffered sw to 0x100, ld_req=1 ld_addr=0x102 -> ld_hazard=1, store drains next cycle, then
//    ld_hazard=0 and en=0.
//  5 full buffer with pop and push in same cycle -> push rejected, count 4->3.
//  6 STORE_ALIGN_CHK_EN: sw addr=0x41 -> st_ades=1, count unchanged; without macro -> enqueued, addr 0x40.

Source files
------------

// File: rtl/mem_store_buffer.sv
// Purpose  : in-order store buffer between EX and the shared data SRAM port; packs sb/sh/sw into lanes.
// Latency  : a store accepted at edge N can drive the SRAM port in cycle N+1 at the earliest (no bypass).
// Backpress: st_ready drops while all DEPTH entries are occupied; a same-cycle pop does not reopen it.
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   st_valid/st_op/st_addr/st_data -> st_ready, st_ades    store request from EX ({sw,sh,sb} one-hot op)
//   ld_req/ld_addr -> ld_hazard                            MEM load arbitration and overlap detection
//   data_sram_en/wen/addr/wdata                            drain side of the shared SRAM port
//   sb_empty, sb_count                                     occupancy status
//
// Optional feature: define STORE_ALIGN_CHK_EN to flag and drop misaligned sh/sw stores via st_ades.
// Without it st_ades is tied low, sh uses addr[1] only and sw ignores addr[1:0].
module mem_store_buffer #(
    parameter int DEPTH = 4,
    parameter int PTR_W = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             st_valid,
    input  logic [2:0]       st_op,
    input  logic [31:0]      st_addr,
    input  logic [31:0]      st_data,
    output logic             st_ready,
    output logic             st_ades,
    input  logic             ld_req,
    input  logic [31:0]      ld_addr,
    output logic             ld_hazard,
    output logic             data_sram_en,
    output logic [3:0]       data_sram_wen,
    output logic [31:0]      data_sram_addr,
    output logic [31:0]      data_sram_wdata,
    output logic             sb_empty,
    output logic [PTR_W:0]   sb_count
);

    localparam logic [PTR_W:0] FULL_CNT = (PTR_W + 1)'(DEPTH);
    localparam logic [PTR_W:0] CNT_ONE  = (PTR_W + 1)'(1);
    localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);

    // Entry storage: word address, byte enables, lane-replicated data.
    logic [29:0]      ent_addr  [DEPTH];
    logic [3:0]       ent_wen   [DEPTH];
    logic [31:0]      ent_wdata [DEPTH];
    logic [DEPTH-1:0] ent_vld;

    logic [PTR_W-1:0] head;
    logic [PTR_W-1:0] tail;
    logic [PTR_W:0]   count;

    logic             sel_sw, sel_sh, sel_sb;
    logic [3:0]       enq_wen;
    logic [31:0]      enq_wdata;
    logic             push, pop, drain;

    // Load address byte offset is irrelevant: hazard detection is word granular.
    logic             ld_addr_unused;
    assign ld_addr_unused = ^ld_addr[1:0];

    // Priority decode when more than one op bit is set: sw > sh > sb.
    assign sel_sw = st_op[2];
    assign sel_sh = !st_op[2] && st_op[1];
    assign sel_sb = !st_op[2] && !st_op[1] && st_op[0];

    always_comb begin
        enq_wen   = 4'b0000;
        enq_wdata = 32'h0;
        if (sel_sw) begin
            enq_wen   = 4'b1111;
            enq_wdata = st_data;
        end else if (sel_sh) begin
            enq_wen   = st_addr[1] ? 4'b1100 : 4'b0011;
            enq_wdata = {2{st_data[15:0]}};
        end else if (sel_sb) begin
            enq_wen   = 4'b0001 << st_addr[1:0];
            enq_wdata = {4{st_data[7:0]}};
        end
    end

`ifdef STORE_ALIGN_CHK_EN
    assign st_ades = st_valid && ((sel_sh && st_addr[0]) || (sel_sw && (st_addr[1:0] != 2'b00)));
`else
    assign st_ades = 1'b0;
`endif

    assign sb_count = count;
    assign sb_empty = (count == '0);
    assign st_ready = (count != FULL_CNT);

    // Word-granular overlap against every occupied entry, regardless of byte enables.
    always_comb begin
        ld_hazard = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (ent_vld[i] && (ent_addr[i] == ld_addr[31:2])) begin
                ld_hazard = ld_req;
            end
        end
    end

    // A hazarding load yields the port so the conflicting store can retire.
    assign drain = !sb_empty && (!ld_req || ld_hazard);
    assign pop   = drain;
    assign push  = st_valid && st_ready && (st_op != 3'b000) && !st_ades;

    always_comb begin
        data_sram_en    = 1'b0;
        data_sram_wen   = 4'b0000;
        data_sram_addr  = 32'h0;
        data_sram_wdata = 32'h0;
        if (drain) begin
            data_sram_en    = 1'b1;
            data_sram_wen   = ent_wen[head];
            data_sram_addr  = {ent_addr[head], 2'b00};
            data_sram_wdata = ent_wdata[head];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            head    <= '0;
            tail    <= '0;
            count   <= '0;
            ent_vld <= '0;
        end else begin
            if (push) begin
                tail <= tail + PTR_ONE;
            end
            if (pop) begin
                head <= head + PTR_ONE;
            end
            // Push and pop target different slots: push is gated off when full,
            // so tail never equals head while the head entry is being popped.
            for (int i = 0; i < DEPTH; i++) begin
                if (push && (tail == PTR_W'(i))) begin
                    ent_vld[i] <= 1'b1;
                end else if (pop && (head == PTR_W'(i))) begin
                    ent_vld[i] <= 1'b0;
                end
            end
            case ({push, pop})
                2'b10:   count <= count + CNT_ONE;
                2'b01:   count <= count - CNT_ONE;
                default: count <= count;
            endcase
        end
    end

    // Payload needs no reset; occupancy is tracked by ent_vld and count.
    always_ff @(posedge clk) begin
        if (push) begin
            ent_addr[tail]  <= st_addr[31:2];
            ent_wen[tail]   <= enq_wen;
            ent_wdata[tail] <= enq_wdata;
        end
    end

endmodule

// File: tb/tb_mem_store_buffer.sv
// Purpose  : directed self-checking bench for mem_store_buffer.
// Latency  : inputs driven 1ns after the rising edge, outputs sampled 1ns later.
// Backpress: exercises full-buffer rejection and load/drain arbitration.
module tb_mem_store_buffer;

    logic        clk;
    logic        rst;
    logic        st_valid;
    logic [2:0]  st_op;
    logic [31:0] st_addr;
    logic [31:0] st_data;
    logic        st_ready;
    logic        st_ades;
    logic        ld_req;
    logic [31:0] ld_addr;
    logic        ld_hazard;
    logic        data_sram_en;
    logic [3:0]  data_sram_wen;
    logic [31:0] data_sram_addr;
    logic [31:0] data_sram_wdata;
    logic        sb_empty;
    logic [2:0]  sb_count;

    int total = 0;
    int bad   = 0;

    mem_store_buffer #(.DEPTH(4), .PTR_W(2)) dut (
        .clk             (clk),
        .rst             (rst),
        .st_valid        (st_valid),
        .st_op           (st_op),
        .st_addr         (st_addr),
        .st_data         (st_data),
        .st_ready        (st_ready),
        .st_ades         (st_ades),
        .ld_req          (ld_req),
        .ld_addr         (ld_addr),
        .ld_hazard       (ld_hazard),
        .data_sram_en    (data_sram_en),
        .data_sram_wen   (data_sram_wen),
        .data_sram_addr  (data_sram_addr),
        .data_sram_wdata (data_sram_wdata),
        .sb_empty        (sb_empty),
        .sb_count        (sb_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_st(input logic v, input logic [2:0] op, input logic [31:0] a, input logic [31:0] d);
        st_valid = v;
        st_op    = op;
        st_addr  = a;
        st_data  = d;
    endtask

    task automatic check_port(input string tag, input logic [3:0] wen, input logic [31:0] a, input logic [31:0] d);
        check({tag, "_en"},    32'(data_sram_en),  32'd1);
        check({tag, "_wen"},   32'(data_sram_wen), 32'(wen));
        check({tag, "_addr"},  data_sram_addr,     a);
        check({tag, "_wdata"}, data_sram_wdata,    d);
    endtask

    initial begin
        rst = 1'b1;
        drive_st(1'b0, 3'b000, 32'h0, 32'h0);
        ld_req  = 1'b0;
        ld_addr = 32'h0;
        step();
        step();
        rst = 1'b0;
        #1;

        // Reset state
        check("rst_empty", 32'(sb_empty),        32'd1);
        check("rst_ready", 32'(st_ready),        32'd1);
        check("rst_count", 32'(sb_count),        32'd0);
        check("rst_en",    32'(data_sram_en),    32'd0);
        check("rst_wen",   32'(data_sram_wen),   32'd0);
        check("rst_addr",  data_sram_addr,       32'd0);
        check("rst_wdata", data_sram_wdata,      32'd0);
        check("rst_haz",   32'(ld_hazard),       32'd0);
        check("rst_ades",  32'(st_ades),         32'd0);

        // 1: sb to 0x13, no same-cycle bypass, drains next cycle
        step();
        drive_st(1'b1, 3'b001, 32'h13, 32'hAB);
        #1;
        check("t1_nobypass", 32'(data_sram_en), 32'd0);
        step();
        drive_st(1'b0, 3'b000, 32'h0, 32'h0);
        #1;
        check("t1_count", 32'(sb_count), 32'd1);
        check_port("t1", 4'b1000, 32'h10, 32'hABABABAB);
        step();
        #1;
        check("t1_empty", 32'(sb_empty), 32'd1);
        check("t1_idle",  32'(data_sram_en), 32'd0);

        // 2: sh then sw back to back, drain in order
        step();
        drive_st(1'b1, 3'b010, 32'h22, 32'h1234);
        step();
        drive_st(1'b1, 3'b100, 32'h40, 32'hDEADBEEF);
        #1;
        check_port("t2a", 4'b1100, 32'h20, 32'h12341234);
        step();
        drive_st(1'b0, 3'b000, 32'h0, 32'h0);
        #1;
        check_port("t2b", 4'b1111, 32'h40, 32'hDEADBEEF);
        step();
        #1;
        check("t2_empty", 32'(sb_empty), 32'd1);

        // 3: load holds port, fill to 4, 5th rejected, then 4 consecutive drains
        ld_req  = 1'b1;
        ld_addr = 32'h800;
        for (int i = 0; i < 4; i++) begin
            drive_st(1'b1, 3'b100, 32'h200 + 32'(4 * i), 32'(i + 1));
            #1;
            check("t3_hold_en", 32'(data_sram_en), 32'd0);
            step();
        end
        check("t3_full_cnt",   32'(sb_count), 32'd4);
        check("t3_full_ready", 32'(st_ready), 32'd0);
        drive_st(1'b1, 3'b100, 32'h210, 32'h99);
        step();
        check("t3_reject_cnt", 32'(sb_count), 32'd4);
        drive_st(1'b0, 3'b000, 32'h0, 32'h0);
        ld_req = 1'b0;
        for (int i = 0; i < 4; i++) begin
            #1;
            check_port("t3_drain", 4'b1111, 32'h200 + 32'(4 * i), 32'(i + 1));
            step();
        end
        check("t3_empty", 32'(sb_empty), 32'd1);

        // 4: load hazard on a buffered word forces drain, then clears
        ld_req  = 1'b1;
        ld_addr = 32'h800;
        drive_st(1'b1, 3'b100, 32'h100, 32'h55);
        step();
        drive_st(1'b0, 3'b000, 32'h0, 32'h0);
        #1;
        check("t4_nohaz", 32'(ld_hazard), 32'd0);
        ld_addr = 32'h102;
        #1;
        check("t4_haz", 32'(ld_hazard), 32'd1);
        check_port("t4", 4'b1111, 32'h100, 32'h55);
        step();
        check("t4_haz_clr", 32'(ld_hazard),    32'd0);
        check("t4_en_clr",  32'(data_sram_en), 32'd0);
        check("t4_empty",   32'(sb_empty),     32'd1);

        // 5: full buffer, pop and push same cycle -> push rejected, 4 -> 3
        ld_addr = 32'h800;
        for (int i = 0; i < 4; i++) begin
            drive_st(1'b1, 3'b100, 32'h300 + 32'(4 * i), 32'h30 + 32'(i));
            step();
        end
        ld_req = 1'b0;
        drive_st(1'b1, 3'b100, 32'h400, 32'h44);
        #1;
        check("t5_ready", 32'(st_ready), 32'd0);
        check_port("t5_pop", 4'b1111, 32'h300, 32'h30);
        step();
        drive_st(1'b0, 3'b000, 32'h0, 32'h0);
        check("t5_count", 32'(sb_count), 32'd3);
        step();
        step();
        step();
        check("t5_empty", 32'(sb_empty), 32'd1);

        // Priority decode and lane packing: sh+sb set -> sh; sb at offset 1; op 0 ignored
        ld_req = 1'b1;
        drive_st(1'b1, 3'b011, 32'h22, 32'h0000BEEF);
        step();
        drive_st(1'b1, 3'b001, 32'h11, 32'h000001CD);
        step();
        drive_st(1'b1, 3'b000, 32'h50, 32'h12);
        step();
        drive_st(1'b0, 3'b000, 32'h0, 32'h0);
        check("pk_count", 32'(sb_count), 32'd2);
        ld_req = 1'b0;
        #1;
        check_port("pk_sh", 4'b1100, 32'h20, 32'hBEEFBEEF);
        step();
        check_port("pk_sb", 4'b0010, 32'h10, 32'hCDCDCDCD);
        step();
        check("pk_empty", 32'(sb_empty), 32'd1);

        // 6: misaligned sw
        ld_req = 1'b1;
        drive_st(1'b1, 3'b100, 32'h41, 32'h77);
        #1;
`ifdef STORE_ALIGN_CHK_EN
        check("t6_ades", 32'(st_ades), 32'd1);
        step();
        drive_st(1'b0, 3'b000, 32'h0, 32'h0);
        check("t6_count", 32'(sb_count), 32'd0);
`else
        check("t6_ades", 32'(st_ades), 32'd0);
        step();
        drive_st(1'b0, 3'b000, 32'h0, 32'h0);
        check("t6_count", 32'(sb_count), 32'd1);
        ld_req = 1'b0;
        #1;
        check_port("t6", 4'b1111, 32'h40, 32'h77);
`endif
        step();
        ld_req = 1'b0;
        step();
        check("t6_empty", 32'(sb_empty), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
